// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and helpers for the memory-port arbiter: FSM states,
// line layout and line-address alignment.
package mem_arb_pkg;

    localparam int LINE_WORDS = 4;
    localparam int ARB_DATA_W = 32;

    typedef logic [LINE_WORDS-1:0][ARB_DATA_W-1:0] line_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WRITE  = 3'd1,
        ST_READ   = 3'd2,
        ST_DONE_W = 3'd3,
        ST_DONE_R = 3'd4
    } arb_state_e;

    // Aligns any address (up to 64 bits) to its 4-word line.
    function automatic logic [63:0] line_addr(input logic [63:0] addr);
        return {addr[63:2], 2'b00};
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the cache/write-buffer pair, the arbiter and memory.
// master = arbiter view, slave = environment (cache, buffer, memory) view.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    import mem_arb_pkg::*;

    logic [LINE_WORDS-1:0]             wb_head_valid;
    logic [LINE_WORDS-1:0][ADDR_W-1:0] wb_head_addr;
    logic [LINE_WORDS-1:0][DATA_W-1:0] wb_head_data;
    logic                              wb_full;
    logic                              wb_pop;

    logic                              rd_req_valid;
    logic [ADDR_W-1:0]                 rd_req_addr;
    logic                              rd_hazard;
    logic                              rd_resp_valid;
    logic [LINE_WORDS-1:0][DATA_W-1:0] rd_resp_data;

    logic                              mem_req_valid;
    logic                              mem_req_we;
    logic [ADDR_W-1:0]                 mem_req_addr;
    logic [LINE_WORDS-1:0][DATA_W-1:0] mem_req_wdata;
    logic [LINE_WORDS-1:0]             mem_req_mask;
    logic                              mem_resp_valid;
    logic [LINE_WORDS-1:0][DATA_W-1:0] mem_resp_rdata;

    modport master (
        input  wb_head_valid, wb_head_addr, wb_head_data, wb_full,
        output wb_pop,
        input  rd_req_valid, rd_req_addr, rd_hazard,
        output rd_resp_valid, rd_resp_data,
        output mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_mask,
        input  mem_resp_valid, mem_resp_rdata
    );

    modport slave (
        output wb_head_valid, wb_head_addr, wb_head_data, wb_full,
        input  wb_pop,
        output rd_req_valid, rd_req_addr, rd_hazard,
        input  rd_resp_valid, rd_resp_data,
        input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_mask,
        output mem_resp_valid, mem_resp_rdata
    );

endinterface

// File: rtl/mem_port_arbiter_grant.sv
// Idle-state grant policy: forced writes (full buffer, RAW hazard, read
// streak exhausted, nothing else to do) beat reads; hazarded reads wait.
module mem_arb_grant #(
    parameter int READ_STREAK_MAX = 4,
    parameter int STREAK_W        = 3
) (
    input  logic                wr_pending,
    input  logic                rd_valid,
    input  logic                rd_hazard,
    input  logic                wb_full,
    input  logic [STREAK_W-1:0] streak,
    output logic                grant_w,
    output logic                grant_r
);

    // Priority decision evaluated every idle cycle.
    always_comb begin
        grant_w = 1'b0;
        grant_r = 1'b0;
        if (wr_pending && (wb_full || (rd_hazard && rd_valid) ||
                           (streak >= STREAK_W'(READ_STREAK_MAX)) || !rd_valid)) begin
            grant_w = 1'b1;
        end else if (rd_valid && !rd_hazard) begin
            grant_r = 1'b1;
        end else begin
            grant_w = 1'b0;
            grant_r = 1'b0;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single memory port shared by write-buffer drains and read-miss refills,
// one transaction at a time, with read-after-write ordering protection.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int READ_STREAK_MAX = 4,
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mem_port_arbiter_if.master   bus
);

    localparam int STREAK_W = $clog2(READ_STREAK_MAX + 1);

    arb_state_e                        state_r;
    logic [STREAK_W-1:0]               streak_r;
    logic                              wr_at_grant_r;
    logic                              wb_pop_r;
    logic                              rd_resp_valid_r;
    logic [LINE_WORDS-1:0][DATA_W-1:0] rd_resp_data_r;
    logic                              mem_valid_r;
    logic                              mem_we_r;
    logic [ADDR_W-1:0]                 mem_addr_r;
    logic [LINE_WORDS-1:0][DATA_W-1:0] mem_wdata_r;
    logic [LINE_WORDS-1:0]             mem_mask_r;

    logic                              wr_pending_s;
    logic                              grant_w_s;
    logic                              grant_r_s;
    logic [1:0]                        low_idx_s;

    assign wr_pending_s = |bus.wb_head_valid;

    mem_arb_grant #(
        .READ_STREAK_MAX (READ_STREAK_MAX),
        .STREAK_W        (STREAK_W)
    ) u_grant (
        .wr_pending (wr_pending_s),
        .rd_valid   (bus.rd_req_valid),
        .rd_hazard  (bus.rd_hazard),
        .wb_full    (bus.wb_full),
        .streak     (streak_r),
        .grant_w    (grant_w_s),
        .grant_r    (grant_r_s)
    );

    // Lowest-indexed valid word of the head line supplies the write address.
    always_comb begin
        low_idx_s = 2'd0;
        casez (bus.wb_head_valid)
            4'b???1: low_idx_s = 2'd0;
            4'b??10: low_idx_s = 2'd1;
            4'b?100: low_idx_s = 2'd2;
            4'b1000: low_idx_s = 2'd3;
            default: low_idx_s = 2'd0;
        endcase
    end

    // Transaction FSM; all bus outputs are registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r         <= ST_IDLE;
            streak_r        <= '0;
            wr_at_grant_r   <= 1'b0;
            wb_pop_r        <= 1'b0;
            rd_resp_valid_r <= 1'b0;
            rd_resp_data_r  <= '0;
            mem_valid_r     <= 1'b0;
            mem_we_r        <= 1'b0;
            mem_addr_r      <= '0;
            mem_wdata_r     <= '0;
            mem_mask_r      <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (grant_w_s) begin
                        state_r     <= ST_WRITE;
                        mem_valid_r <= 1'b1;
                        mem_we_r    <= 1'b1;
                        mem_addr_r  <= ADDR_W'(line_addr(64'(bus.wb_head_addr[low_idx_s])));
                        mem_wdata_r <= bus.wb_head_data;
                        mem_mask_r  <= bus.wb_head_valid;
                    end else if (grant_r_s) begin
                        state_r       <= ST_READ;
                        mem_valid_r   <= 1'b1;
                        mem_we_r      <= 1'b0;
                        mem_addr_r    <= ADDR_W'(line_addr(64'(bus.rd_req_addr)));
                        mem_wdata_r   <= '0;
                        mem_mask_r    <= '0;
                        wr_at_grant_r <= wr_pending_s;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_WRITE: begin
                    if (bus.mem_resp_valid) begin
                        state_r     <= ST_DONE_W;
                        mem_valid_r <= 1'b0;
                        wb_pop_r    <= 1'b1;
                        streak_r    <= '0;
                    end else begin
                        state_r <= ST_WRITE;
                    end
                end
                ST_READ: begin
                    if (bus.mem_resp_valid) begin
                        state_r         <= ST_DONE_R;
                        mem_valid_r     <= 1'b0;
                        rd_resp_valid_r <= 1'b1;
                        rd_resp_data_r  <= bus.mem_resp_rdata;
                        // Only reads that bypassed a waiting write count toward starvation.
                        if (wr_at_grant_r && (streak_r < STREAK_W'(READ_STREAK_MAX))) begin
                            streak_r <= streak_r + STREAK_W'(1);
                        end else begin
                            streak_r <= streak_r;
                        end
                    end else begin
                        state_r <= ST_READ;
                    end
                end
                ST_DONE_W, ST_DONE_R: begin
                    wb_pop_r        <= 1'b0;
                    rd_resp_valid_r <= 1'b0;
                    state_r         <= ST_IDLE;
                end
                default: begin
                    state_r         <= ST_IDLE;
                    mem_valid_r     <= 1'b0;
                    wb_pop_r        <= 1'b0;
                    rd_resp_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.wb_pop        = wb_pop_r;
    assign bus.rd_resp_valid = rd_resp_valid_r;
    assign bus.rd_resp_data  = rd_resp_data_r;
    assign bus.mem_req_valid = mem_valid_r;
    assign bus.mem_req_we    = mem_we_r;
    assign bus.mem_req_addr  = mem_addr_r;
    assign bus.mem_req_wdata = mem_wdata_r;
    assign bus.mem_req_mask  = mem_mask_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: reads, writes, RAW hazard, read
// streak limit, full-buffer priority and reset during a read.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   err_cnt = 0;
    int   chk_cnt = 0;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus();

    mem_port_arbiter #(
        .READ_STREAK_MAX (4),
        .ADDR_W          (32),
        .DATA_W          (32)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(input string tag, output int n);
        n = 0;
        while (!bus.mem_req_valid && n < 20) begin
            tick();
            n++;
        end
        check_val({tag, "_req_seen"}, bus.mem_req_valid, 1'b1);
    endtask

    task automatic mem_reply(input int lat, input line_t data);
        repeat (lat) tick();
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_rdata = data;
        tick();
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_rdata = '0;
    endtask

    initial begin
        int    n;
        line_t rd_line;
        logic [6:0] exp_we;

        rst_n              = 1'b1;
        bus.wb_head_valid  = '0;
        bus.wb_head_addr   = '0;
        bus.wb_head_data   = '0;
        bus.wb_full        = 1'b0;
        bus.rd_req_valid   = 1'b0;
        bus.rd_req_addr    = '0;
        bus.rd_hazard      = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_rdata = '0;
        #1 rst_n = 1'b0;
        repeat (3) tick();
        check_val("rst_mem_valid", bus.mem_req_valid, 1'b0);
        check_val("rst_wb_pop", bus.wb_pop, 1'b0);
        check_val("rst_rd_resp_valid", bus.rd_resp_valid, 1'b0);
        check_val("rst_rd_resp_data", bus.rd_resp_data, 128'd0);
        check_val("rst_mem_addr", bus.mem_req_addr, 32'd0);
        rst_n = 1'b1;
        tick();

        // Read only
        bus.rd_req_addr  = 32'h103;
        bus.rd_req_valid = 1'b1;
        wait_req("rd", n);
        check_val("rd_latency", 32'(n), 32'd1);
        check_val("rd_addr", bus.mem_req_addr, 32'h100);
        check_val("rd_we", bus.mem_req_we, 1'b0);
        check_val("rd_mask", bus.mem_req_mask, 4'b0000);
        rd_line = {32'd4, 32'd3, 32'd2, 32'd1};
        tick();
        check_val("rd_req_stable", bus.mem_req_valid, 1'b1);
        mem_reply(1, rd_line);
        check_val("rd_resp_valid", bus.rd_resp_valid, 1'b1);
        check_val("rd_resp_data", bus.rd_resp_data, rd_line);
        check_val("rd_req_drop", bus.mem_req_valid, 1'b0);
        check_val("rd_no_pop", bus.wb_pop, 1'b0);
        bus.rd_req_valid = 1'b0;
        tick();
        check_val("rd_resp_pulse", bus.rd_resp_valid, 1'b0);

        // Write only, mask 0101
        bus.wb_head_addr  = {32'h0, 32'h42, 32'h0, 32'h40};
        bus.wb_head_data  = {32'h0, 32'hB, 32'h0, 32'hA};
        bus.wb_head_valid = 4'b0101;
        wait_req("wr", n);
        check_val("wr_we", bus.mem_req_we, 1'b1);
        check_val("wr_addr", bus.mem_req_addr, 32'h40);
        check_val("wr_mask", bus.mem_req_mask, 4'b0101);
        check_val("wr_data", bus.mem_req_wdata, {32'h0, 32'hB, 32'h0, 32'hA});
        mem_reply(2, '0);
        check_val("wr_pop", bus.wb_pop, 1'b1);
        check_val("wr_no_rd_resp", bus.rd_resp_valid, 1'b0);
        bus.wb_head_valid = 4'b0000;
        tick();
        check_val("wr_pop_pulse", bus.wb_pop, 1'b0);

        // RAW hazard: write first, read only after drain
        bus.wb_head_addr  = {32'h0, 32'h0, 32'h201, 32'h200};
        bus.wb_head_data  = {32'h0, 32'h0, 32'h22, 32'h11};
        bus.wb_head_valid = 4'b0011;
        bus.rd_req_addr   = 32'h201;
        bus.rd_req_valid  = 1'b1;
        bus.rd_hazard     = 1'b1;
        wait_req("haz_w", n);
        check_val("haz_first_we", bus.mem_req_we, 1'b1);
        check_val("haz_first_addr", bus.mem_req_addr, 32'h200);
        mem_reply(1, '0);
        check_val("haz_pop", bus.wb_pop, 1'b1);
        bus.wb_head_valid = 4'b0000;
        bus.rd_hazard     = 1'b0;
        wait_req("haz_r", n);
        check_val("haz_second_we", bus.mem_req_we, 1'b0);
        check_val("haz_second_addr", bus.mem_req_addr, 32'h200);
        rd_line = {32'h44, 32'h33, 32'h22, 32'h11};
        mem_reply(1, rd_line);
        check_val("haz_rd_data", bus.rd_resp_data, rd_line);
        bus.rd_req_valid = 1'b0;
        tick();

        // Full buffer beats a clean read; lowest valid word is index 3
        bus.wb_head_addr  = {32'h30E, 32'h0, 32'h0, 32'h0};
        bus.wb_head_data  = {32'h77, 32'h0, 32'h0, 32'h0};
        bus.wb_head_valid = 4'b1000;
        bus.wb_full       = 1'b1;
        bus.rd_req_addr   = 32'h500;
        bus.rd_req_valid  = 1'b1;
        wait_req("full_w", n);
        check_val("full_we", bus.mem_req_we, 1'b1);
        check_val("full_addr", bus.mem_req_addr, 32'h30C);
        check_val("full_mask", bus.mem_req_mask, 4'b1000);
        mem_reply(1, '0);
        bus.wb_head_valid = 4'b0000;
        bus.wb_full       = 1'b0;
        wait_req("full_r", n);
        check_val("full_rd_we", bus.mem_req_we, 1'b0);
        check_val("full_rd_addr", bus.mem_req_addr, 32'h500);
        mem_reply(1, '0);
        bus.rd_req_valid = 1'b0;
        tick();

        // Starvation: 4 reads, forced write, then reads resume
        bus.wb_head_addr  = {32'h603, 32'h602, 32'h601, 32'h600};
        bus.wb_head_data  = {32'h4, 32'h3, 32'h2, 32'h1};
        bus.wb_head_valid = 4'b1111;
        bus.rd_req_addr   = 32'h700;
        bus.rd_req_valid  = 1'b1;
        exp_we = 7'b0010000;
        for (int i = 0; i < 7; i++) begin
            wait_req("stv", n);
            check_val($sformatf("stv_we_%0d", i), bus.mem_req_we, exp_we[i]);
            if (exp_we[i]) begin
                check_val("stv_w_addr", bus.mem_req_addr, 32'h600);
                check_val("stv_w_mask", bus.mem_req_mask, 4'b1111);
                mem_reply(1, '0);
                check_val("stv_pop", bus.wb_pop, 1'b1);
                bus.wb_head_valid = 4'b0000;
            end else begin
                rd_line = {96'd0, 32'(i + 100)};
                mem_reply(1, rd_line);
                check_val($sformatf("stv_rd_valid_%0d", i), bus.rd_resp_valid, 1'b1);
                check_val($sformatf("stv_rd_data_%0d", i), bus.rd_resp_data, rd_line);
            end
        end
        bus.rd_req_valid = 1'b0;
        tick();

        // Reset while a read waits on memory
        bus.rd_req_addr  = 32'h804;
        bus.rd_req_valid = 1'b1;
        wait_req("rst_rd", n);
        tick();
        rst_n = 1'b0;
        #1;
        check_val("abort_mem_valid", bus.mem_req_valid, 1'b0);
        check_val("abort_mem_addr", bus.mem_req_addr, 32'd0);
        check_val("abort_rd_data", bus.rd_resp_data, 128'd0);
        check_val("abort_rd_valid", bus.rd_resp_valid, 1'b0);
        bus.rd_req_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        mem_reply(0, {32'hDEAD, 32'hDEAD, 32'hDEAD, 32'hDEAD});
        check_val("late_resp_ignored", bus.rd_resp_valid, 1'b0);
        check_val("late_no_req", bus.mem_req_valid, 1'b0);
        tick();
        check_val("late_resp_ignored2", bus.rd_resp_valid, 1'b0);
        bus.rd_req_addr  = 32'h906;
        bus.rd_req_valid = 1'b1;
        wait_req("post_rst", n);
        check_val("post_rst_addr", bus.mem_req_addr, 32'h904);
        // Requester withdraws mid-read; completion still pulses
        bus.rd_req_valid = 1'b0;
        rd_line = {32'h9, 32'h8, 32'h7, 32'h6};
        mem_reply(1, rd_line);
        check_val("post_rst_valid", bus.rd_resp_valid, 1'b1);
        check_val("post_rst_data", bus.rd_resp_data, rd_line);
        tick();

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
